// File: rtl/spi_pkg.sv
// Types and constants shared by the SPI master and the slave-side receiver.
package spi_pkg;

  localparam int unsigned SPI_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    LAST
  } spi_state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// sck phase timer: pulses phase_end_c once every CLK_DIV clk cycles while run is high.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic phase_end_c
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;

  assign phase_end_c = run && (cnt == CW'(CLK_DIV - 1));

  // Restarts on every phase boundary so each FSM state lasts exactly CLK_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || phase_end_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master, MSB first, count-delimited frames; sck = clk / (2*CLK_DIV).
// Define SPI_MASTER_CS_EN to add an active-low chip-select output.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH   = SPI_WORD_W,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             sck,
  output logic             sdo,
`ifdef SPI_MASTER_CS_EN
  output logic             cs_n,
`endif
  input  logic             sdi
);

  localparam int unsigned BW = $clog2(WIDTH + 1);

  spi_state_t       state, state_d;
  logic [WIDTH-2:0] shreg, shreg_d;   // bits still waiting to go out on sdo
  logic [WIDTH-1:0] rxreg, rxreg_d;
  logic [WIDTH-1:0] q_d;
  logic [BW-1:0]    bitcnt, bitcnt_d;
  logic             sck_d, sdo_d, busy_d, done_d;
  logic             phase_end_c;
`ifdef SPI_MASTER_CS_EN
  logic             cs_n_d;
`endif

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk        (clk),
    .reset      (reset),
    .run        (state != IDLE),
    .phase_end_c(phase_end_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      rxreg  <= '0;
      q      <= '0;
      bitcnt <= '0;
      sck    <= 1'b0;
      sdo    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SPI_MASTER_CS_EN
      cs_n   <= 1'b1;
`endif
    end else begin
      state  <= state_d;
      shreg  <= shreg_d;
      rxreg  <= rxreg_d;
      q      <= q_d;
      bitcnt <= bitcnt_d;
      sck    <= sck_d;
      sdo    <= sdo_d;
      busy   <= busy_d;
      done   <= done_d;
`ifdef SPI_MASTER_CS_EN
      cs_n   <= cs_n_d;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    rxreg_d  = rxreg;
    q_d      = q;
    bitcnt_d = bitcnt;
    sck_d    = sck;
    sdo_d    = sdo;
    busy_d   = busy;
    done_d   = 1'b0;
`ifdef SPI_MASTER_CS_EN
    cs_n_d   = cs_n;
`endif

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d  = SETUP;
          sdo_d    = d[WIDTH-1];
          shreg_d  = d[WIDTH-2:0];
          bitcnt_d = '0;
          busy_d   = 1'b1;
`ifdef SPI_MASTER_CS_EN
          cs_n_d   = 1'b0;
`endif
        end
      end
      SETUP, LOW: begin
        if (phase_end_c) begin
          state_d = HIGH;
          sck_d   = 1'b1;
        end
      end
      HIGH: begin
        // Capture at the end of the high phase, then present the next bit with the falling edge.
        if (phase_end_c) begin
          sck_d    = 1'b0;
          rxreg_d  = {rxreg[WIDTH-2:0], sdi};
          bitcnt_d = bitcnt + BW'(1);
          if (bitcnt == BW'(WIDTH - 1)) begin
            state_d = LAST;
          end else begin
            state_d = LOW;
            sdo_d   = shreg[WIDTH-2];
            shreg_d = shreg << 1;
          end
        end
      end
      LAST: begin
        if (phase_end_c) begin
          state_d = IDLE;
          q_d     = rxreg;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef SPI_MASTER_CS_EN
          cs_n_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx with a bit-level slave model on the SPI pins.
module tb_spi_master_tx;

  localparam int W  = 32;
  localparam int CD = 2;
  localparam int FRAME = (2 * W + 1) * CD + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] d;
  logic         busy, done, sck, sdo, sdi;
  logic [W-1:0] q;
`ifdef SPI_MASTER_CS_EN
  logic         cs_n;
`endif

  int tests = 0;
  int fails = 0;

  // Slave model state: mode 0 = slave word, 1 = loopback, 2 = sdi tied high.
  int           mode = 1;
  logic [W-1:0] sw_cur = '0;
  int           fall_cnt = 0;
  int           fall_base = 0;
  logic [W-1:0] slave_rx = '0;

  spi_master_tx #(
    .WIDTH  (W),
    .CLK_DIV(CD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .d    (d),
    .busy (busy),
    .done (done),
    .q    (q),
    .sck  (sck),
    .sdo  (sdo),
`ifdef SPI_MASTER_CS_EN
    .cs_n (cs_n),
`endif
    .sdi  (sdi)
  );

  always #5 clk = ~clk;

  always @(negedge sck) fall_cnt <= fall_cnt + 1;
  always @(posedge sck) slave_rx <= {slave_rx[W-2:0], sdo};

  // Slave presents bit n of its word after its n-th falling sck edge of the frame.
  always_comb begin
    int idx;
    idx = fall_cnt - fall_base;
    if (mode == 1)                 sdi = sdo;
    else if (mode == 2)            sdi = 1'b1;
    else if (idx >= 0 && idx < W)  sdi = sw_cur[W-1-idx];
    else                           sdi = 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input logic [W-1:0] dv, input int m, input logic [W-1:0] sw,
                           input bit poke);
    int           done_at, busy_n, rises, cs_bad;
    logic         prev_sck;
    logic [W-1:0] exp_q;
    exp_q = (m == 0) ? sw : (m == 1) ? dv : {W{1'b1}};
    @(negedge clk);
    mode = m; sw_cur = sw; fall_base = fall_cnt;
    d = dv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_at = -1; busy_n = 0; rises = 0; cs_bad = 0; prev_sck = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (poke && k == 10) begin start = 1'b1; d = ~dv; end
      if (poke && k == 11) start = 1'b0;
      if (sck && !prev_sck) begin
        if (rises < W) chk("sdo_at_rise", 64'(sdo), 64'(dv[W-1-rises]));
        rises++;
      end
      prev_sck = sck;
      if (done) begin
        done_at = k;
        chk("busy_in_done", 64'(busy), 64'd0);
`ifdef SPI_MASTER_CS_EN
        chk("cs_n_in_done", 64'(cs_n), 64'd1);
`endif
        break;
      end
      if (busy) busy_n++;
`ifdef SPI_MASTER_CS_EN
      if (cs_n !== 1'b0) cs_bad++;
`endif
    end
    chk("done_cycle", 64'(done_at), 64'(FRAME));
    chk("busy_cycles", 64'(busy_n), 64'(FRAME - 1));
    chk("sck_rises", 64'(rises), 64'(W));
    chk("q", 64'(q), 64'(exp_q));
    chk("slave_rx", 64'(slave_rx), 64'(dv));
`ifdef SPI_MASTER_CS_EN
    chk("cs_n_low_in_frame", 64'(cs_bad), 64'd0);
`endif
    if (poke) begin
      repeat (5) @(negedge clk);
      chk("ignored_start", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] dh;
    int           dn, bad;
    reset = 1'b1; start = 1'b0; d = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_sdo", 64'(sdo), 64'd0);
`ifdef SPI_MASTER_CS_EN
    chk("rst_cs_n", 64'(cs_n), 64'd1);
`endif
    reset = 1'b0;

    run_frame(32'hA5C30F01, 1, '0, 1'b0);
    run_frame(32'h00000000, 2, '0, 1'b0);
    run_frame(32'hDEADBEEF, 0, 32'h12345678, 1'b0);
    chk("sdo_holds_last", 64'(sdo), 64'd1);
`ifdef SPI_MASTER_CS_EN
    chk("idle_cs_n", 64'(cs_n), 64'd1);
`endif

    // Abort a frame with reset 40 cycles after acceptance.
    @(negedge clk);
    mode = 1; d = $urandom | 32'h80000000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sck", 64'(sck), 64'd0);
    chk("abort_sdo", 64'(sdo), 64'd0);
    chk("abort_q", 64'(q), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (150) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    run_frame(32'($urandom), 0, 32'($urandom), 1'b0);

    run_frame(32'($urandom), 1, '0, 1'b1);

    // start held high: back-to-back frames, busy low only in each done cycle.
    dh = 32'($urandom);
    @(negedge clk);
    mode = 1; d = dh; start = 1'b1;
    @(posedge clk);
    bad = 0;
    for (int k = 1; k <= 3 * FRAME; k++) begin
      @(negedge clk);
      if (done !== (k % FRAME == 0) || busy !== (k % FRAME != 0)) bad++;
      if (k % FRAME == 0) chk("held_q", 64'(q), 64'(dh));
      if (k == 3 * FRAME) start = 1'b0;
    end
    chk("held_pattern", 64'(bad), 64'd0);
    repeat (5) @(negedge clk);
    chk("held_stop_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 4; i++) begin
      run_frame(32'($urandom), int'($urandom_range(0, 1)), 32'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

FPGA-side SPI master: serialises a WIDTH-bit word onto sdo and simultaneously captures WIDTH bits from sdi. The clock it drives on sck is divided down from clk. Bits move MSB first in mode 0, the same framing the existing slave-side receiver expects: data captured on the rising sck edge, changed on the falling edge, frames delimited purely by bit count. It sits between the signal-processing datapath (filtered samples, peak counts) and an external SPI slave such as a display driver, DAC or the microcontroller in a reversed-role link.

## Interface
- WIDTH, 32, bits per frame; must be ≥ 2.
- CLK_DIV, 4, clk cycles per sck half-period; must be ≥ 1.

- clk  in  1  system clock; all state on posedge clk.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request a frame; sampled only while busy=0.
- d  in  WIDTH  word to transmit; latched on the clk edge that accepts start.
- busy  out  1  high for the whole frame.
- done  out  1  one-cycle pulse when the frame completes.
- q  out  WIDTH  word received; updated only on the done cycle.
- sck  out  1  serial clock; idles low.
- sdo  out  1  serial data to the slave.
- sdi  in  1  serial data from the slave.
- cs_n  out  1  active-low select; present only with SPI_MASTER_CS_EN.

## Operation
- Reset values: busy=0, done=0, q=0, sck=0, sdo=0, cs_n=1, state IDLE.
- States:
  - IDLE: start=1 moves to SETUP. The accepting edge loads shreg←d and drives sdo←d[WIDTH-1]. The bit counter is cleared.
  - SETUP: sck low for CLK_DIV cycles, then to HIGH.
  - HIGH: sck=1 for CLK_DIV cycles. On the edge that ends HIGH:
    - sck←0;
    - rxreg←{rxreg[WIDTH-2:0], sdi}, using the pre-edge value of sdi;
    - bit counter increments.
    - If bit counter = WIDTH-1 before the increment, go to LAST. Otherwise shift shreg left, drive sdo←next bit and go to LOW.
  - LOW: sck=0 for CLK_DIV cycles, then to HIGH.
  - LAST: sck=0 for CLK_DIV cycles. On the exiting edge: q←rxreg, done←1, busy←0, return to IDLE.
- start while busy=1 is ignored, with no queuing.
- start during the done cycle is accepted: back-to-back frames with one idle-visible cycle between them.
- sdo holds its last transmitted bit after the frame and does not return to 0 until the next load or reset.
- Reset mid-frame aborts immediately: no done pulse, q keeps its reset value of 0, sck goes low at once.
- Counters:
  - bit counter width is $clog2(WIDTH+1);
  - divider counter width is $clog2(CLK_DIV+1);
  - no wrap is possible inside a frame.

## Timing
- Start accepted at edge t. busy=1 from t+1 through t+(2·WIDTH+1)·CLK_DIV.
- done is high in cycle t+(2·WIDTH+1)·CLK_DIV+1, and busy=0 in that same cycle.
- First sck rise at edge t+CLK_DIV+1. Exactly WIDTH rising edges per frame.
- sdo is stable for a full sck period around each rising edge. A slave's setup and hold are each ≥ CLK_DIV clk cycles.
- sdi is sampled CLK_DIV cycles after the sck rise. The slave must update sdi only on the falling edge.

## Configuration
- SPI_MASTER_CS_EN defined:
  - cs_n port exists;
  - cs_n goes to 0 on the start-accept edge and returns to 1 on the done edge;
  - the frame timing is unchanged.
- SPI_MASTER_CS_EN undefined: no cs_n port, and frames are delimited by count only (slave-compatible mode).

## Structure
- Shared package spi_pkg:
  - spi_state_t enum {IDLE, SETUP, HIGH, LOW, LAST};
  - localparam SPI_WORD_W = 32, which is the default for WIDTH and is shared with the slave.
- One sub-module, spi_sck_gen: CLK_DIV divider producing a one-cycle phase_end pulse. It is cleared on every state change, and the FSM advances on phase_end.

## Test plan
- WIDTH=32, CLK_DIV=2, sdi tied to sdo, start with d=0xA5C30F01 → done at t+131, q=0xA5C30F01, busy high for exactly 130 cycles, 32 sck rises.
- sdi tied to 1, d=0x00000000 → q=0xFFFFFFFF; sdo=0 at every sck rise.
- Bench-model slave returning 0x12345678 (changes on falling sck) while d=0xDEADBEEF → q=0x12345678; the slave captures 0xDEADBEEF.
- Assert reset at t+40 → busy=0, sck=0, sdo=0, q=0 immediately, and no done pulse. A fresh start then produces a full correct frame.
- start held high continuously → frames repeat with busy low only during each done cycle; a start pulse at t+10 is ignored.
- With SPI_MASTER_CS_EN: cs_n=0 exactly from t+1 to the done edge, 1 at reset and in idle.
